// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width and the rx/tx handshake state type.
package uart_pkg;
  localparam int UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_LOW = 2'd2
  } hs_state_t;
endpackage

// File: rtl/uart_rx_fifo_if.sv
// Bus between uart_rx / CPU register logic and uart_rx_fifo.
//   rx_data, rx_full, rx_ack          : byte handshake with uart_rx
//   rd_data, rd_valid, rd_strobe      : FWFT read port
//   count, overflow, overflow_clear   : status
// slave = the FIFO block, master = its environment.
interface uart_rx_fifo_if
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) ();
  logic [UART_BYTE_W-1:0] rx_data;
  logic                   rx_full;
  logic                   rx_ack;
  logic [UART_BYTE_W-1:0] rd_data;
  logic                   rd_valid;
  logic                   rd_strobe;
  logic [DEPTH_LOG2:0]    count;
  logic                   overflow;
  logic                   overflow_clear;

  modport slave (
    input  rx_data, rx_full, rd_strobe, overflow_clear,
    output rx_ack, rd_data, rd_valid, count, overflow
  );

  modport master (
    output rx_data, rx_full, rd_strobe, overflow_clear,
    input  rx_ack, rd_data, rd_valid, count, overflow
  );
endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Generic synchronous FIFO: storage array plus wrap-bit pointers.
//   clk, rst           : clock, synchronous active-high reset
//   push, push_data    : write one entry (caller guarantees room)
//   pop                : drop head entry (caller guarantees non-empty)
//   head               : raw storage at read pointer (not gated)
//   count, full, empty : occupancy
module sync_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [AW:0]  count,
  output logic         full,
  output logic         empty
);
  localparam int unsigned DEPTH = 1 << AW;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Contents need no reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Wrap bit makes the difference span 0..DEPTH without ambiguity.
  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (count == (AW+1)'(DEPTH));
  assign head  = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind uart_rx: one capture per rx_full assertion, FWFT
// read port, sticky overflow so uart_rx is never back-pressured.
//   clk, rst : clock, synchronous active-high reset
//   bus      : uart_rx_fifo_if.slave (handshake, read port, status)
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_fifo_if.slave  bus
);
  hs_state_t              state, state_nxt;
  logic                   capture, ack;
  logic                   pop_en, push_en, ovf_set, ovf;
  logic                   full, empty;
  logic [UART_BYTE_W-1:0] head;
  logic [DEPTH_LOG2:0]    count;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Capture only happens on the IDLE->ACK edge, so a long rx_full pulse
  // yields one byte.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    ack       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.rx_full) begin
          capture   = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK: begin
        ack       = 1'b1;
        state_nxt = bus.rx_full ? WAIT_LOW : IDLE;
      end
      WAIT_LOW: begin
        ack = 1'b1;
        if (!bus.rx_full) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A same-cycle pop frees the slot a full FIFO needs.
  assign pop_en  = bus.rd_strobe & ~empty;
  assign push_en = capture & (~full | pop_en);
  assign ovf_set = capture & ~push_en;

  always_ff @(posedge clk) begin
    if (rst)                     ovf <= 1'b0;
    else if (ovf_set)            ovf <= 1'b1;
    else if (bus.overflow_clear) ovf <= 1'b0;
  end

  sync_fifo #(
    .W  (UART_BYTE_W),
    .AW (DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_en),
    .push_data (bus.rx_data),
    .pop       (pop_en),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign bus.rx_ack   = ack;
  assign bus.rd_valid = ~empty;
  assign bus.rd_data  = empty ? '0 : head;
  assign bus.count    = count;
  assign bus.overflow = ovf;
endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
  localparam int DL = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DEPTH_LOG2(DL)) bus ();

  uart_rx_fifo #(.DEPTH_LOG2(DL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  // Abstract model: queue of stored bytes, "handshake in progress" flag,
  // sticky overflow.
  logic [7:0] q[$];
  bit  busy = 0;
  bit  movf = 0;
  int  ack_hi = 0;
  int  peak = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    bit pop, cap, set;
    @(posedge clk);
    if (rst) begin
      q.delete();
      busy = 0;
      movf = 0;
    end else begin
      pop = bus.rd_strobe && (q.size() > 0);
      cap = !busy && bus.rx_full;
      set = 0;
      if (pop) void'(q.pop_front());
      if (cap) begin
        if (q.size() < DEPTH) q.push_back(bus.rx_data);
        else set = 1;
      end
      if (!busy) busy = bus.rx_full;
      else if (!bus.rx_full) busy = 0;
      if (set) movf = 1;
      else if (bus.overflow_clear) movf = 0;
    end
    @(negedge clk);
    chk("rd_valid", 32'(bus.rd_valid), 32'(q.size() != 0));
    chk("rd_data", 32'(bus.rd_data), (q.size() != 0) ? 32'(q[0]) : 32'h0);
    chk("count", 32'(bus.count), 32'(q.size()));
    chk("rx_ack", 32'(bus.rx_ack), 32'(busy));
    chk("overflow", 32'(bus.overflow), 32'(movf));
    if (bus.rx_ack) ack_hi++;
    if (int'(bus.count) > peak) peak = int'(bus.count);
  endtask

  task automatic send(logic [7:0] b, int hold);
    bus.rx_data = b;
    bus.rx_full = 1'b1;
    repeat (hold) tick();
    bus.rx_full = 1'b0;
    tick();
  endtask

  task automatic pop1();
    bus.rd_strobe = 1'b1;
    tick();
    bus.rd_strobe = 1'b0;
  endtask

  initial begin
    logic [7:0] last;
    logic [7:0] exp3 [3];
    bus.rx_data = 8'h00;
    bus.rx_full = 1'b0;
    bus.rd_strobe = 1'b0;
    bus.overflow_clear = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick(); tick();
    chk("reset count", 32'(bus.count), 32'd0);
    chk("reset rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("reset rx_ack", 32'(bus.rx_ack), 32'd0);
    rst = 1'b0;
    tick();

    // rd_strobe while empty is ignored
    pop1();
    chk("empty pop count", 32'(bus.count), 32'd0);

    // single byte, rx_full held 3 cycles
    ack_hi = 0;
    send(8'hB2, 3);
    tick();
    chk("single count", 32'(bus.count), 32'd1);
    chk("single data", 32'(bus.rd_data), 32'hB2);
    chk("single valid", 32'(bus.rd_valid), 32'd1);
    chk("single ack cycles", 32'(ack_hi), 32'd3);
    pop1();
    chk("single pop valid", 32'(bus.rd_valid), 32'd0);
    chk("single pop data", 32'(bus.rd_data), 32'h00);

    // back-to-back
    peak = 0;
    send(8'h00, 1); send(8'hFF, 1); send(8'h5A, 1);
    chk("b2b peak", 32'(peak), 32'd3);
    exp3[0] = 8'h00; exp3[1] = 8'hFF; exp3[2] = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      chk("b2b order", 32'(bus.rd_data), 32'(exp3[i]));
      pop1();
    end
    chk("b2b drained", 32'(bus.count), 32'd0);

    // overflow: 17 bytes into 16 slots
    for (int i = 1; i <= 17; i++) send(8'(i), 1);
    chk("ovf count", 32'(bus.count), 32'd16);
    chk("ovf flag", 32'(bus.overflow), 32'd1);
    chk("ovf head", 32'(bus.rd_data), 32'h01);
    bus.overflow_clear = 1'b1; tick(); bus.overflow_clear = 1'b0;
    chk("ovf cleared", 32'(bus.overflow), 32'd0);

    // full FIFO, capture with simultaneous pop
    bus.rx_data = 8'hC3; bus.rx_full = 1'b1; bus.rd_strobe = 1'b1;
    tick();
    bus.rd_strobe = 1'b0; bus.rx_full = 1'b0;
    tick();
    chk("fullpop count", 32'(bus.count), 32'd16);
    chk("fullpop ovf", 32'(bus.overflow), 32'd0);
    chk("fullpop head", 32'(bus.rd_data), 32'h02);
    last = 8'h00;
    for (int i = 0; i < 16; i++) begin
      last = bus.rd_data;
      pop1();
    end
    chk("fullpop last", 32'(last), 32'hC3);

    // overflow set beats clear
    for (int i = 0; i < 16; i++) send(8'(8'h40 + i), 1);
    bus.rx_data = 8'hAA; bus.rx_full = 1'b1; bus.overflow_clear = 1'b1;
    tick();
    bus.overflow_clear = 1'b0; bus.rx_full = 1'b0;
    tick();
    chk("set wins", 32'(bus.overflow), 32'd1);
    bus.overflow_clear = 1'b1; tick(); bus.overflow_clear = 1'b0;
    chk("clear alone", 32'(bus.overflow), 32'd0);

    // reset mid-handshake with 5 stored
    rst = 1'b1; tick(); rst = 1'b0; tick();
    for (int i = 0; i < 4; i++) send(8'(8'h10 + i), 1);
    bus.rx_data = 8'h7E; bus.rx_full = 1'b1;
    tick();
    chk("pre-reset count", 32'(bus.count), 32'd5);
    chk("pre-reset ack", 32'(bus.rx_ack), 32'd1);
    rst = 1'b1; tick();
    chk("midrst count", 32'(bus.count), 32'd0);
    chk("midrst ack", 32'(bus.rx_ack), 32'd0);
    chk("midrst valid", 32'(bus.rd_valid), 32'd0);
    rst = 1'b0;
    tick(); tick();
    bus.rx_full = 1'b0;
    tick(); tick();
    chk("post-reset count", 32'(bus.count), 32'd1);
    chk("post-reset data", 32'(bus.rd_data), 32'h7E);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Sits directly downstream of uart_rx and consumes its rx_data/rx_full/ack handshake.
- Captures each received byte exactly once into a small synchronous FIFO.
- Presents a first-word-fall-through read port to the CPU-side register logic.
- Keeps a sticky overflow flag so uart_rx never stalls when software falls behind.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (default 16 entries).

Ports:
- clock  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  8  byte from uart_rx; valid while rx_full=1.
- rx_full  in  1  uart_rx holds a byte; stays high until ack is seen.
- rx_ack  out  1  acknowledge to uart_rx (its ack input).
- rd_data  out  8  head-of-FIFO byte; 8'h00 when rd_valid=0.
- rd_valid  out  1  FIFO not empty.
- rd_strobe  in  1  pop head entry this cycle.
- count  out  DEPTH_LOG2+1  number of stored bytes, 0..2^DEPTH_LOG2.
- overflow  out  1  sticky: a byte was dropped because the FIFO was full.
- overflow_clear  in  1  clears overflow.

Behaviour:
- Reset (synchronous, active-high; takes effect at the clock edge, including mid-handshake or mid-transfer):
  - rx_ack=0, rd_valid=0, rd_data=8'h00, count=0, overflow=0.
  - Pointers zeroed and FSM forced to IDLE; FIFO contents discarded.
- Handshake FSM, three states:
  - IDLE: rx_ack=0. If rx_full=1, capture rx_data (push or drop, see below) at this edge and go to ACK.
  - ACK: rx_ack=1. If rx_full=0, go to IDLE; otherwise go to WAIT_LOW.
  - WAIT_LOW: rx_ack=1. Stay until rx_full=0, then go to IDLE.
  - Each rx_full assertion therefore causes exactly one capture, even if uart_rx takes several cycles to drop rx_full.
  - A byte whose rx_full is still high after reset is captured once, in IDLE.
- Capture timing:
  - rx_full first sampled high at edge N: entry written at edge N.
  - rd_valid and count reflect the new entry from cycle N+1.
  - rx_ack is high from cycle N+1 until the cycle after rx_full is sampled low.
- Push acceptance:
  - Accepted if count < 2^DEPTH_LOG2, or if rd_strobe=1 with rd_valid=1 in the same cycle (the pop frees a slot).
  - Otherwise the byte is dropped, overflow is set, and the handshake still completes normally.
- Pop:
  - rd_strobe with rd_valid=1 advances the read pointer; rd_data shows the next entry the following cycle.
  - rd_strobe while empty is ignored: no pointer change, count stays 0.
- Count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Pointers: DEPTH_LOG2+1 bits with a wrap bit, so full and empty are unambiguous; wrap-around is silent.
- rd_data is combinational from the storage array at the read pointer, gated to 8'h00 when empty. There is zero-cycle read latency after rd_valid rises.
- overflow: a set event and overflow_clear in the same cycle resolve to set (set wins). Otherwise overflow_clear clears it at the edge.
- Width rules: count is compared against the full depth value 2^DEPTH_LOG2, never truncated.

Decomposition:
- Shared package uart_pkg:
  - UART_BYTE_W = 8.
  - Handshake state typedef (IDLE, ACK, WAIT_LOW), shared with any future TX-side FIFO.
- One natural sub-module: sync_fifo, a generic width/depth storage-plus-pointers block with push/pop/count/full/empty.
- uart_rx_fifo = handshake FSM + overflow logic + a sync_fifo instance.

Test Plan:
- Single byte: rx_data=8'hB2, rx_full high for 3 cycles then low -> exactly one entry; rd_valid=1, rd_data=8'hB2, count=1; rx_ack high for 3 cycles; pop -> rd_valid=0, rd_data=8'h00.
- Back-to-back: bytes 8'h00, 8'hFF, 8'h5A delivered with minimal gaps -> read out in order, count peaks at 3, no duplicates.
- Overflow: push 17 bytes (8'h01..8'h11) with default depth, no pops -> count=16, overflow=1, head=8'h01, byte 8'h11 lost; every rx_ack pulse still completes.
- Full with simultaneous pop: FIFO full, pop in the same cycle as capture of 8'hC3 -> count stays 16, overflow stays 0, 8'hC3 is the last entry read.
- Overflow set vs clear: overflow_clear asserted in the same cycle as a drop -> overflow=1; later clear alone -> 0.
- Reset mid-handshake: reset in the ACK state with 5 bytes stored -> next cycle count=0, rx_ack=0, rd_valid=0. If rx_full is still high with 8'h7E, that byte is captured once after reset.
